alu_arbiter: RTL

Two-requester round-robin arbiter that shares the single 64-bit ALU between the integer issue path (requester 0) and the address-generation path (requester 1). It accepts one operation at a time and drives the registered operands and opcode onto the ALU's A/B/ALUControl inputs. It captures Result/Zero and returns them to the owning requester over a valid/ready response channel. The block sits beside the ALU in the core top level; the ALU itself stays outside and connects through the alu_* ports.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_arbiter_rr_arb2.sv | 17 +
 rtl/alu_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes and FSM states for the ALU arbiter
package alu_pkg;

  localparam int WIDTH = 64;
  localparam int OPW   = 4;

  localparam logic [OPW-1:0] OP_ADD = 4'd0;
  localparam logic [OPW-1:0] OP_SUB = 4'd1;
  localparam logic [OPW-1:0] OP_AND = 4'd2;
  localparam logic [OPW-1:0] OP_OR  = 4'd3;
  localparam logic [OPW-1:0] OP_XOR = 4'd4;
  localparam logic [OPW-1:0] OP_SLL = 4'd5;
  localparam logic [OPW-1:0] OP_SRL = 4'd6;
  localparam logic [OPW-1:0] OP_MAX = OP_SRL;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rtl/alu_arbiter_rr_arb2.sv - two-way round-robin grant, combinational
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one external ALU between two requesters
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH  = alu_pkg::WIDTH,
  parameter int OPW    = alu_pkg::OPW,
  parameter int MAX_OP = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [OPW-1:0]   req_op0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [OPW-1:0]   req_op1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  localparam logic [OPW-1:0] MAX_OP_L = OPW'(MAX_OP);

  state_t           state;
  logic             rr_ptr;
  logic             owner;
  logic [1:0]       gnt;
  logic             g;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [OPW-1:0]   sel_op;

  rr_arb2 u_rr_arb2 (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  // Gated by rst_n so the handshake is dead while reset is held.
  assign req_ready = (state == IDLE && rst_n) ? gnt : 2'b00;

  assign g      = gnt[1];
  assign sel_a  = g ? req_a1  : req_a0;
  assign sel_b  = g ? req_b1  : req_b0;
  assign sel_op = g ? req_op1 : req_op0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      rsp_valid  <= 2'b00;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // alu_* only load on acceptance, so the ALU inputs stay quiet while idle.
          if (|(req_valid & req_ready)) begin
            owner    <= g;
            alu_a    <= sel_a;
            alu_b    <= sel_b;
            alu_ctrl <= sel_op;
            rsp_err  <= (sel_op > MAX_OP_L);
            state    <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_valid  <= owner ? 2'b10 : 2'b01;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= 2'b00;
            rr_ptr    <= ~owner;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
